intersection_arbiter: RTL

//   Arbitrates one two-way intersection (north, west) between pulsed crossing requests.

---
 rtl/intersection_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/intersection_arbiter.sv
// Two-way (north/west) intersection arbiter: latches pulsed requests, sequences
// green -> yellow -> all-red clearance per direction, round-robin on ties.
module intersection_arbiter #(
  parameter int unsigned GREEN_CYCLES  = 3,
  parameter int unsigned YELLOW_CYCLES = 1,
  parameter int unsigned CLEAR_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       n,
  input  logic       w,
  output logic [1:0] light_n,
  output logic [1:0] light_w,
  output logic       pend_n,
  output logic       pend_w,
  output logic       busy
);

  localparam int unsigned MAX_GY  = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_GY > CLEAR_CYCLES) ? MAX_GY : CLEAR_CYCLES;
  localparam int unsigned CNT_W   = (MAX_ALL < 1) ? 1 : $clog2(MAX_ALL + 1);

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_GREEN  = 2'b01;
  localparam logic [1:0] LAMP_YELLOW = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GREEN_N  = 3'd1,
    YELLOW_N = 3'd2,
    GREEN_W  = 3'd3,
    YELLOW_W = 3'd4,
    CLEAR    = 3'd5
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               last_w, last_w_next;   // 1: west was served last
  logic               pend_n_next, pend_w_next;
  logic [1:0]         light_n_next, light_w_next;
  logic               busy_next;
  logic               dn, dw, grant_n, grant_w, decide;

  // State, phase counter, latches and registered lamp outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      last_w  <= 1'b1;
      pend_n  <= 1'b0;
      pend_w  <= 1'b0;
      light_n <= LAMP_RED;
      light_w <= LAMP_RED;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      last_w  <= last_w_next;
      pend_n  <= pend_n_next;
      pend_w  <= pend_w_next;
      light_n <= light_n_next;
      light_w <= light_w_next;
      busy    <= busy_next;
    end
  end

  // Next-state, request latching, grant decision and next lamp values
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    last_w_next  = last_w;
    pend_n_next  = pend_n;
    pend_w_next  = pend_w;
    light_n_next = LAMP_RED;
    light_w_next = LAMP_RED;
    busy_next    = 1'b0;
    decide       = 1'b0;

    dn      = n | pend_n;
    dw      = w | pend_w;
    grant_n = dn & (~dw | last_w);
    grant_w = dw & (~dn | ~last_w);

    case (state)
      IDLE: decide = 1'b1;
      GREEN_N: begin
        pend_w_next = pend_w | w;
        if (cnt == '0) begin
          state_next = YELLOW_N;
          cnt_next   = CNT_W'(YELLOW_CYCLES - 1);
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      GREEN_W: begin
        pend_n_next = pend_n | n;
        if (cnt == '0) begin
          state_next = YELLOW_W;
          cnt_next   = CNT_W'(YELLOW_CYCLES - 1);
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      YELLOW_N, YELLOW_W: begin
        pend_n_next = pend_n | n;
        pend_w_next = pend_w | w;
        if (cnt == '0) begin
          state_next = CLEAR;
          cnt_next   = CNT_W'(CLEAR_CYCLES - 1);
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      CLEAR: begin
        pend_n_next = pend_n | n;
        pend_w_next = pend_w | w;
        if (cnt == '0) begin
          decide = 1'b1;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // Grant: winner's pend is cleared (same-cycle request absorbed), loser's demand latched
    if (decide) begin
      if (grant_n) begin
        state_next  = GREEN_N;
        cnt_next    = CNT_W'(GREEN_CYCLES - 1);
        pend_n_next = 1'b0;
        pend_w_next = dw;
        last_w_next = 1'b0;
      end else if (grant_w) begin
        state_next  = GREEN_W;
        cnt_next    = CNT_W'(GREEN_CYCLES - 1);
        pend_w_next = 1'b0;
        pend_n_next = dn;
        last_w_next = 1'b1;
      end else begin
        state_next  = IDLE;
        cnt_next    = '0;
        pend_n_next = 1'b0;
        pend_w_next = 1'b0;
      end
    end

    case (state_next)
      GREEN_N:  light_n_next = LAMP_GREEN;
      YELLOW_N: light_n_next = LAMP_YELLOW;
      GREEN_W:  light_w_next = LAMP_GREEN;
      YELLOW_W: light_w_next = LAMP_YELLOW;
      default: ;
    endcase
    busy_next = (state_next != IDLE);
  end

endmodule
